dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter for the data port of the segmented unified memory (address, write enable, write data, read data). It shares that port between the pipeline MEM stage (CPU) and the image/data loader (DMA). CPU has fixed priority, and a starvation guard forces a DMA grant. The block issues one access per cycle, checks each address against the populated segment range, and routes the one-cycle-late read data back to the requester that issued the access.

## Interface
Parameters:
- WIDTH, 32, data and address width
- RAMSIZE, 16, words per data segment
- NSEG, 6, number of data segments; valid addresses are 0 .. RAMSIZE*NSEG-1
- MAXWAIT, 4, consecutive denied DMA cycles before DMA gets forced priority (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  WIDTH  CPU word address
- cpu_wd  in  WIDTH  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU response pulse
- cpu_rdata  out  WIDTH  CPU read data
- cpu_fault  out  1  CPU out-of-range flag, valid with cpu_rvalid
- dma_req, dma_we, dma_addr, dma_wd  in  1/1/WIDTH/WIDTH  DMA request, same meaning as CPU
- dma_gnt, dma_rvalid, dma_rdata, dma_fault  out  1/1/WIDTH/1  DMA response, same meaning as CPU
- mem_we  out  1  memory write enable
- mem_a  out  WIDTH  memory data address
- mem_wd  out  WIDTH  memory write data
- mem_rd  in  WIDTH  memory read data; valid the cycle after the address is presented

## Operation
- Priority FSM has two states: CPU_PRIO (reset state) and DMA_PRIO.
- Grant logic is combinational from the req inputs and the FSM state:
  - CPU_PRIO: cpu_gnt = cpu_req; dma_gnt = dma_req & ~cpu_req.
  - DMA_PRIO: dma_gnt = dma_req; cpu_gnt = cpu_req & ~dma_req.
- At most one grant per cycle. A requester holds req and its fields stable until it sees gnt.
- Memory mux:
  - mem_a and mem_wd come from the granted requester; if nothing is granted, they come from the CPU.
  - mem_we = granted_we & in_range.
  - in_range = (addr < RAMSIZE*NSEG), compared unsigned at full WIDTH.
- An out-of-range access is still granted and consumed. It never asserts mem_we.
- Wait counter (clog2(MAXWAIT+1) bits):
  - Increments when dma_req & ~dma_gnt.
  - Clears to 0 when dma_gnt is asserted.
  - Saturates at MAXWAIT.
- FSM transitions:
  - CPU_PRIO → DMA_PRIO when the counter would reach MAXWAIT this cycle.
  - DMA_PRIO → CPU_PRIO on any cycle with dma_gnt.
  - If dma_req drops while in DMA_PRIO, the FSM stays in DMA_PRIO. The counter holds.
- Response register: on each grant, register owner, fault = ~in_range, and a valid bit.
  - Next cycle, the owner's rvalid pulses high for one cycle.
  - The owner's rdata = mem_rd if it was an in-range read, else 0.
  - The owner's fault = registered fault.
  - The non-owner's rvalid, rdata and fault are all 0.
- Writes also produce the rvalid acknowledge, with rdata = 0.
- Reset (rst_n sampled low on an edge):
  - FSM → CPU_PRIO; counter → 0; response valid bit → 0. A pending response is dropped.
  - While rst_n is low, cpu_gnt, dma_gnt and mem_we are forced to 0.

## Timing
- Reset values: cpu_gnt, dma_gnt, mem_we = 0 while rst_n is low; cpu_rvalid, dma_rvalid, cpu_fault, dma_fault = 0; cpu_rdata, dma_rdata = 0.
- Grant latency is 0 cycles: gnt is in the same cycle as req.
- Response latency is 1 cycle: rvalid is in cycle N+1 for a grant in cycle N.
- Back-to-back grants give back-to-back rvalid pulses. Throughput is 1 access per cycle.
- A write in cycle N followed by a read of the same address in cycle N+1 returns the new data. The memory provides write-then-read ordering across cycles; the arbiter adds no bypass.
- With MAXWAIT = 4, continuous cpu_req and continuous dma_req, the DMA is granted at most 5 cycles after its first request.
- Boundaries:
  - Address RAMSIZE*NSEG-1 (95 with defaults) is in range.
  - Address 96 and addresses with upper bits set (e.g. 0xFFFF_FFF0) are faults. No wrap-around occurs.

## Test plan
- Reset: hold rst_n=0 with both reqs high → both gnt=0, mem_we=0, all rvalid=0. Release → CPU granted first cycle.
- CPU write 0xDEADBEEF to addr 20, then CPU read addr 20 → mem_we=1 with mem_a=20. cpu_rvalid pulses each following cycle. Second response has cpu_rdata=0xDEADBEEF, cpu_fault=0. dma_rvalid stays 0.
- Contention with MAXWAIT=4, both reqs held high for 12 cycles → grant pattern CPU×4, DMA×1, CPU×4, DMA×1, CPU×2. Counter returns to 0 after each DMA grant.
- Range check: DMA write to addr 95 → mem_we=1. DMA write to addr 96 → mem_we=0, dma_rvalid with dma_fault=1. DMA read at 0xFFFF_FFF0 → dma_rdata=0, dma_fault=1.
- Reset mid-operation: CPU read granted in cycle N, rst_n=0 in cycle N → no cpu_rvalid in N+1. FSM and counter are back at CPU_PRIO/0.
- DMA_PRIO hold: reach DMA_PRIO, drop dma_req for 3 cycles with CPU requesting → CPU granted meanwhile. dma_req returns → immediate dma_gnt, FSM back to CPU_PRIO.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data port of the segmented unified memory.
// The CPU (MEM stage) has fixed priority. A wait counter forces one DMA grant
// after MAXWAIT consecutive denied DMA cycles. Every access is range-checked
// against the populated segments. The one-cycle-late read data is routed back
// to the requester that issued the access.
//
// state    | meaning
// CPU_PRIO | CPU wins contention; DMA denials are counted
// DMA_PRIO | DMA wins contention; left on the first DMA grant
module dmem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int RAMSIZE = 16,
    parameter int NSEG    = 6,
    parameter int MAXWAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wd,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_fault,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_addr,
    input  logic [WIDTH-1:0] dma_wd,
    output logic             dma_gnt,
    output logic             dma_rvalid,
    output logic [WIDTH-1:0] dma_rdata,
    output logic             dma_fault,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int CW = $clog2(MAXWAIT + 1);
    localparam logic [CW-1:0]    WAIT_MAX = CW'(MAXWAIT);
    localparam logic [WIDTH-1:0] ADDR_LIM = WIDTH'(RAMSIZE * NSEG);

    typedef enum logic {
        CPU_PRIO = 1'b0,
        DMA_PRIO = 1'b1
    } prio_t;

    prio_t         state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;

    logic rsp_valid_q;
    logic rsp_dma_q;
    logic rsp_fault_q;
    logic rsp_rd_q;

    logic gnt_any;
    logic gnt_we;
    logic in_range;
    logic [WIDTH-1:0] rsp_data;

    // Grants from requests and priority state; nothing is granted in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            if (state_q == DMA_PRIO) begin
                dma_gnt = dma_req;
                cpu_gnt = cpu_req & ~dma_req;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req & ~cpu_req;
            end
        end
    end

    // Memory port mux; the CPU drives the address bus when the port is idle.
    always_comb begin
        gnt_any  = cpu_gnt | dma_gnt;
        mem_a    = dma_gnt ? dma_addr : cpu_addr;
        mem_wd   = dma_gnt ? dma_wd   : cpu_wd;
        gnt_we   = dma_gnt ? dma_we   : cpu_we;
        in_range = (mem_a < ADDR_LIM);
        mem_we   = gnt_any & gnt_we & in_range;
    end

    // Next priority state and DMA wait count.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (dma_gnt) begin
            wait_d  = '0;
            state_d = CPU_PRIO;
        end else if (dma_req) begin
            if (wait_q < WAIT_MAX) begin
                wait_d = wait_q + CW'(1);
            end
            if (wait_d == WAIT_MAX) begin
                state_d = DMA_PRIO;
            end
        end
    end

    // Priority state and wait counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CPU_PRIO;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Response tracking: who owns next cycle's mem_rd and what it means.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_dma_q   <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            rsp_valid_q <= gnt_any;
            rsp_dma_q   <= dma_gnt;
            rsp_fault_q <= gnt_any & ~in_range;
            rsp_rd_q    <= gnt_any & ~gnt_we & in_range;
        end
    end

    // Route the response to its owner; the other side sees all zeros.
    always_comb begin
        rsp_data   = rsp_rd_q ? mem_rd : '0;
        cpu_rvalid = rsp_valid_q & ~rsp_dma_q;
        dma_rvalid = rsp_valid_q &  rsp_dma_q;
        cpu_rdata  = cpu_rvalid ? rsp_data : '0;
        dma_rdata  = dma_rvalid ? rsp_data : '0;
        cpu_fault  = cpu_rvalid & rsp_fault_q;
        dma_fault  = dma_rvalid & rsp_fault_q;
    end

endmodule
